servo_sequencer: RTL and testbench



---
 rtl/servo_pkg.sv | 32 +++
 rtl/servo_sequencer_if.sv | 23 ++
 rtl/servo_frame_tick.sv | 29 ++
 rtl/servo_sequencer.sv | 148 ++++++++++++++
 tb/tb_servo_sequencer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// Shared types and helpers for the SG90 servo position sequencer.
package servo_pkg;

  // Top-level sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    SWEEP = 2'd2
  } state_e;

  // Position index range: 0 = full right, 3 = middle, 6 = full left.
  localparam logic [2:0] IDX_MIN = 3'd0;
  localparam logic [2:0] IDX_MID = 3'd3;
  localparam logic [2:0] IDX_MAX = 3'd6;

  // Translate a position index into the servo driver's one-hot code.
  // Middle (3) is the driver's default, encoded as all zeros.
  function automatic logic [5:0] idx_to_pos(input logic [2:0] idx);
    logic [5:0] code;
    case (idx)
      3'd0:    code = 6'b000001;
      3'd1:    code = 6'b000010;
      3'd2:    code = 6'b000100;
      3'd4:    code = 6'b001000;
      3'd5:    code = 6'b010000;
      3'd6:    code = 6'b100000;
      default: code = 6'b000000;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/servo_sequencer_if.sv
// Command handshake between control logic and the servo sequencer.
interface servo_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_target;
  logic       sweep_en;

  // Control logic side: issues commands and sweep requests.
  modport master (
    output cmd_valid,
    output cmd_target,
    output sweep_en,
    input  cmd_ready
  );

  // Sequencer side: accepts commands.
  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  sweep_en,
    output cmd_ready
  );
endinterface

// File: rtl/servo_frame_tick.sv
// Free-running frame counter producing a one-cycle tick every FRAME_CYCLES
// clocks. Intentionally not phase-locked to any driver frame.
module servo_frame_tick #(
  parameter int FRAME_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // Count 0..FRAME_CYCLES-1 and wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/servo_sequencer.sv
// Slew-limited position sequencer for the SG90 servo driver: accepts target
// commands, steps one index per HOLD_FRAMES frames, and can sweep 0<->6.
module servo_sequencer #(
  parameter int FRAME_CYCLES = 2000000,
  parameter int HOLD_FRAMES  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  servo_sequencer_if.slave    cmd,
  output logic [5:0]          pos,
  output logic [2:0]          cur_idx,
  output logic                busy,
  output logic                done
);
  import servo_pkg::*;

  localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

  state_e        state_q, state_d;
  logic [2:0]    cur_idx_q, cur_idx_d;
  logic [2:0]    target_q, target_d;
  logic          dir_up_q, dir_up_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          done_q, done_d;
  logic [5:0]    pos_q;

  logic       frame_tick;
  logic       step_evt;
  logic [2:0] cmd_tgt_sat;
  logic [2:0] move_next;
  logic [2:0] sweep_next;

  servo_frame_tick #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_frame_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick_o(frame_tick)
  );

  assign step_evt    = frame_tick && (hold_q == HOLD_LAST);
  // Index 7 does not exist; clamp it to full left.
  assign cmd_tgt_sat = (cmd.cmd_target == 3'd7) ? IDX_MAX : cmd.cmd_target;
  // Only used while cur_idx differs from the target / is inside the sweep
  // range in the chosen direction, so neither expression can wrap.
  assign move_next   = (target_q > cur_idx_q) ? cur_idx_q + 3'd1 : cur_idx_q - 3'd1;
  assign sweep_next  = dir_up_q ? cur_idx_q + 3'd1 : cur_idx_q - 3'd1;

  // Next-state logic for the IDLE/MOVE/SWEEP controller.
  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    target_d  = target_q;
    dir_up_d  = dir_up_q;
    hold_d    = hold_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (cmd.cmd_valid) begin
          target_d = cmd_tgt_sat;
          if (cmd_tgt_sat == cur_idx_q) begin
            done_d = 1'b1;
          end else begin
            state_d = MOVE;
          end
        end else if (cmd.sweep_en) begin
          state_d  = SWEEP;
          dir_up_d = (cur_idx_q != IDX_MAX);
        end
      end

      MOVE: begin
        if (frame_tick) begin
          hold_d = step_evt ? '0 : hold_q + 1'b1;
        end
        if (step_evt) begin
          cur_idx_d = move_next;
          if (move_next == target_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      SWEEP: begin
        if (!cmd.sweep_en) begin
          // Leave immediately; any partially accumulated hold is dropped.
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          if (frame_tick) begin
            hold_d = step_evt ? '0 : hold_q + 1'b1;
          end
          if (step_evt) begin
            cur_idx_d = sweep_next;
            if (sweep_next == IDX_MAX) begin
              dir_up_d = 1'b0;
            end else if (sweep_next == IDX_MIN) begin
              dir_up_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_idx_q <= IDX_MID;
      target_q  <= IDX_MID;
      dir_up_q  <= 1'b1;
      hold_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      target_q  <= target_d;
      dir_up_q  <= dir_up_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
    end
  end

  // Register the driver code from the current index so pos has no input path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= 6'b000000;
    end else begin
      pos_q <= idx_to_pos(cur_idx_q);
    end
  end

  assign pos           = pos_q;
  assign cur_idx       = cur_idx_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign cmd.cmd_ready = (state_q == IDLE);

endmodule

// File: tb/tb_servo_sequencer.sv
// Directed bench for servo_sequencer with a scoreboard of expected index
// changes and done pulses, each tagged with the clock cycle it must occur on.
module tb_servo_sequencer;

  localparam int FC   = 10;
  localparam int HF   = 2;
  localparam int STEP = FC * HF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] pos;
  logic [2:0] cur_idx;
  logic       busy;
  logic       done;

  servo_sequencer_if bus ();

  servo_sequencer #(
    .FRAME_CYCLES(FC),
    .HOLD_FRAMES (HF)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd    (bus),
    .pos    (pos),
    .cur_idx(cur_idx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;

  exp_t step_q[$];
  exp_t done_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc;
  int model_idx;
  int last_done_cyc;

  function automatic logic [5:0] exp_pos(input int idx);
    case (idx)
      0:       return 6'b000001;
      1:       return 6'b000010;
      2:       return 6'b000100;
      4:       return 6'b001000;
      5:       return 6'b010000;
      6:       return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Posedges since reset release; a frame tick is consumed on multiples of FC.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Model a move command accepted on posedge a.
  task automatic push_move(input int tgt, input int a);
    int t;
    int c;
    t = (tgt > 6) ? 6 : tgt;
    if (t == model_idx) begin
      done_q.push_back('{t, a});
      last_done_cyc = a;
    end else begin
      c = FC * (a / FC + HF);
      while (model_idx != t) begin
        model_idx += (t > model_idx) ? 1 : -1;
        step_q.push_back('{model_idx, c});
        c += STEP;
      end
      done_q.push_back('{t, c - STEP});
      last_done_cyc = c - STEP;
    end
  endtask

  // Model n sweep steps after the sweep is entered on posedge a.
  task automatic push_sweep(input int a, input int n);
    int dir;
    int c;
    dir = (model_idx == 6) ? -1 : 1;
    c   = FC * (a / FC + HF);
    for (int k = 0; k < n; k++) begin
      model_idx += dir;
      step_q.push_back('{model_idx, c});
      if (model_idx == 6)      dir = -1;
      else if (model_idx == 0) dir = 1;
      c += STEP;
    end
  endtask

  task automatic send_cmd(input int tgt);
    chk("cmd_ready_before_accept", {31'd0, bus.cmd_ready}, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = 3'(tgt);
    push_move(tgt, cyc + 1);
    @(negedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((step_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_timeout_pending", step_q.size() + done_q.size(), 0);
  endtask

  // Scoreboard monitor: pops expected index changes and done pulses.
  logic [2:0] prev_idx;
  logic       prev_done;
  bit         prev_valid;
  exp_t       e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_valid) begin
        chk("pos_map", {26'd0, pos}, {26'd0, exp_pos(int'(prev_idx))});
        if (cur_idx !== prev_idx) begin
          if (step_q.size() == 0) begin
            chk("unexpected_idx_change", {29'd0, cur_idx}, {29'd0, prev_idx});
          end else begin
            e = step_q.pop_front();
            chk("step_idx", {29'd0, cur_idx}, e.idx);
            chk("step_cycle", cyc, e.cyc);
          end
        end
      end
      if (done === 1'b1) begin
        chk("done_width", {31'd0, prev_done}, 0);
        if (done_q.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 0);
        end else begin
          e = done_q.pop_front();
          chk("done_idx", {29'd0, cur_idx}, e.idx);
          chk("done_cycle", cyc, e.cyc);
        end
      end
      prev_idx   = cur_idx;
      prev_done  = done;
      prev_valid = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_target = 3'd0;
    bus.sweep_en   = 1'b0;
    model_idx      = 3;
    last_done_cyc  = 0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    // Reset values.
    chk("rst_cur_idx", {29'd0, cur_idx}, 3);
    chk("rst_pos", {26'd0, pos}, 0);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    @(negedge clk); #1;

    // Move 3 -> 6.
    send_cmd(6);
    chk("move_busy", {31'd0, busy}, 1);
    chk("move_cmd_ready", {31'd0, bus.cmd_ready}, 0);
    wait_drain(200);
    chk("t2_done_at_end", {31'd0, done}, 1);
    chk("t2_cmd_ready_back", {31'd0, bus.cmd_ready}, 1);
    chk("t2_busy_low", {31'd0, busy}, 0);
    @(negedge clk); #1;
    chk("t2_pos_full_left", {26'd0, pos}, 6'b100000);
    chk("t2_done_cleared", {31'd0, done}, 0);

    // Target 7 saturates to 6: immediate done, no motion.
    send_cmd(7);
    chk("sat_done", {31'd0, done}, 1);
    chk("sat_busy", {31'd0, busy}, 0);
    chk("sat_cur_idx", {29'd0, cur_idx}, 6);

    // Move 6 -> 0 while a stray command is offered during MOVE.
    send_cmd(0);
    repeat (3) begin @(negedge clk); #1; end
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = 3'd6;
    repeat (5) begin
      @(negedge clk); #1;
      chk("move_ignores_cmd_ready", {31'd0, bus.cmd_ready}, 0);
    end
    bus.cmd_valid = 1'b0;
    wait_drain(300);
    chk("t3_cur_idx", {29'd0, cur_idx}, 0);
    @(negedge clk); #1;
    chk("t3_pos_full_right", {26'd0, pos}, 6'b000001);

    // Back to middle, then sweep 4,5,6,5,4,3,2,1,0,1.
    send_cmd(3);
    wait_drain(200);
    @(negedge clk); #1;
    bus.sweep_en = 1'b1;
    push_sweep(cyc + 1, 10);
    @(negedge clk); #1;
    chk("sweep_busy", {31'd0, busy}, 1);
    chk("sweep_cmd_ready", {31'd0, bus.cmd_ready}, 0);
    wait_drain(400);
    bus.sweep_en = 1'b0;
    @(negedge clk); #1;
    chk("sweep_exit_busy", {31'd0, busy}, 0);
    chk("sweep_exit_idx", {29'd0, cur_idx}, 1);
    repeat (50) begin @(negedge clk); end
    #1;
    chk("sweep_exit_hold_idx", {29'd0, cur_idx}, 1);

    // Command and sweep together: command wins, sweep follows after done.
    bus.sweep_en = 1'b1;
    send_cmd(0);
    chk("prio_cmd_ready", {31'd0, bus.cmd_ready}, 0);
    push_sweep(last_done_cyc + 1, 2);
    wait_drain(300);
    bus.sweep_en = 1'b0;
    @(negedge clk); #1;
    chk("prio_exit_busy", {31'd0, busy}, 0);
    chk("prio_exit_idx", {29'd0, cur_idx}, 2);

    // Accept exactly on a frame-tick cycle: first step 20 cycles later.
    for (int n = 0; n < FC && ((cyc + 1) % FC) != 0; n++) begin
      @(negedge clk); #1;
    end
    send_cmd(4);
    wait_drain(200);
    chk("tick_accept_idx", {29'd0, cur_idx}, 4);
    @(negedge clk); #1;

    // Reset mid-MOVE forces middle immediately.
    send_cmd(6);
    for (int n = 0; n < 100 && step_q.size() > 1; n++) begin
      @(negedge clk); #1;
    end
    chk("premove_steps_left", step_q.size(), 1);
    @(negedge clk); #1;
    chk("premove_pos", {26'd0, pos}, 6'b010000);
    step_q.delete();
    done_q.delete();
    rst_n = 1'b0;
    #1;
    chk("midrst_pos", {26'd0, pos}, 0);
    chk("midrst_cur_idx", {29'd0, cur_idx}, 3);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_cmd_ready", {31'd0, bus.cmd_ready}, 1);
    chk("midrst_done", {31'd0, done}, 0);
    model_idx = 3;
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (30) begin @(negedge clk); end
    #1;
    chk("postrst_idle_idx", {29'd0, cur_idx}, 3);
    chk("postrst_busy", {31'd0, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
